// File: rtl/dbus_responder_pkg.sv
// Shared types and constants for the dbus_responder slice.
// The optional stall feature is enabled with the DBUS_RESP_STALL_EN macro.
package dbus_responder_pkg;

  // Request from the CPU data-bus initiator.
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  // Response back to the initiator.
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  // Stall LFSR: x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
  localparam logic [7:0] DBUS_RESP_LFSR_SEED = 8'hA5;
  localparam logic [7:0] DBUS_RESP_LFSR_TAPS = 8'hB8;

  // One Fibonacci step: the feedback bit is the XOR of the tapped bits.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q, input logic [7:0] taps);
    return {q[6:0], ^(q & taps)};
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus interface bundling the request and response structs.
//
// Handshake: a request is accepted in the cycle where dreq.valid and
// dresp.addr_ok are both 1. The initiator holds valid and all fields stable
// until dresp.data_ok; data_ok is a single-cycle pulse carrying the read data
// (zero for writes). Only one request is outstanding at a time.
interface dbus_responder_if;
  import dbus_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_responder_lfsr8.sv
// 8-bit Fibonacci LFSR used to throttle addr_ok in the stall build.
// Only present when DBUS_RESP_STALL_EN is defined.
`ifdef DBUS_RESP_STALL_EN
module dbus_responder_lfsr8
  import dbus_responder_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_q;

  // Advance one step every cycle; reset reloads the seed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_q <= seed;
    else         r_q <= lfsr8_next(r_q, DBUS_RESP_LFSR_TAPS);
  end

  assign q = r_q;

endmodule
`endif

// File: rtl/dbus_responder.sv
// Memory-side responder for the CPU data bus: word-addressed local SRAM with
// a fixed request-to-data latency. Defining DBUS_RESP_STALL_EN gates addr_ok
// with an LFSR bit to insert pseudo-random handshake delays.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic             clk,
  input  logic             resetn,
  dbus_responder_if.slave  dbus,
  output logic [1:0]       o_dbg_state
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dbus_responder: LATENCY must be in 1..15");
  end
  if ((1 << AW) != MEM_WORDS) begin : g_bad_depth
    $error("dbus_responder: MEM_WORDS must be a power of two");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_strobe;
  logic [31:0]     r_wdata;
  logic [3:0]      r_cnt;
  logic            r_data_ok;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [MEM_WORDS];

  logic            w_stall_ok;
  logic            w_addr_ok;
  logic [AW-1:0]   w_req_idx;
  logic            w_unused;
  dbus_resp_t      w_resp;

`ifdef DBUS_RESP_STALL_EN
  logic [7:0] w_lfsr;

  dbus_responder_lfsr8 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .seed   (DBUS_RESP_LFSR_SEED),
    .q      (w_lfsr)
  );

  assign w_stall_ok = w_lfsr[0];
  assign w_unused   = ^{dbus.dreq.size, dbus.dreq.addr[31:AW+2], dbus.dreq.addr[1:0], w_lfsr[7:1]};
`else
  assign w_stall_ok = 1'b1;
  assign w_unused   = ^{dbus.dreq.size, dbus.dreq.addr[31:AW+2], dbus.dreq.addr[1:0]};
`endif

  // Upper address bits are dropped so addresses wrap modulo MEM_WORDS*4;
  // byte lanes come only from strobe.
  assign w_req_idx = dbus.dreq.addr[AW+1:2];
  assign w_addr_ok = (r_state == IDLE) & dbus.dreq.valid & w_stall_ok;

  // Response bundle: addr_ok is combinational, data_ok/data are registered.
  always_comb begin
    w_resp         = '0;
    w_resp.addr_ok = w_addr_ok;
    w_resp.data_ok = r_data_ok;
    w_resp.data    = r_rdata;
  end

  assign dbus.dresp  = w_resp;
  assign o_dbg_state = r_state;

  // Request FSM: latch at the handshake, count down, pulse data_ok in DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_strobe  <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
      case (r_state)
        IDLE: begin
          if (w_addr_ok) begin
            r_idx    <= w_req_idx;
            r_strobe <= dbus.dreq.strobe;
            r_wdata  <= dbus.dreq.data;
            r_cnt    <= CNT_INIT;
            if (LATENCY == 1) begin
              r_state   <= DONE;
              r_data_ok <= 1'b1;
              r_rdata   <= (dbus.dreq.strobe == 4'h0) ? r_mem[w_req_idx] : 32'h0;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= DONE;
            r_data_ok <= 1'b1;
            // Any earlier write landed at the end of its own DONE, so this read sees it.
            r_rdata   <= (r_strobe == 4'h0) ? r_mem[r_idx] : 32'h0;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte-lane write at the edge that ends DONE; contents survive reset.
  always_ff @(posedge clk) begin
    if (r_state == DONE) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strobe[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Directed and randomized bench for dbus_responder with a word-array model.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int LAT       = 2;
  localparam int HS_MAX    = 64;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_responder_if dif ();
  dbus_req_t  req = '0;
  dbus_resp_t rsp;
  assign dif.dreq = req;
  assign rsp      = dif.dresp;

  dbus_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .dbus        (dif),
    .o_dbg_state (dbg_state)
  );

`ifdef DBUS_RESP_STALL_EN
  // Reference sequence for x^8+x^6+x^5+x^4+1 from seed A5.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 8'hA5;
    else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
`endif

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [MEM_WORDS];
  logic [31:0] exp_q [$];
  logic [31:0] last_rdata;
  int          last_hs = 0;
  bit          in_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr_ok();
`ifdef DBUS_RESP_STALL_EN
    return 32'(req.valid & m_lfsr[0]);
`else
    return 32'(req.valid);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic reset_dut(input int n);
    resetn    = 1'b0;
    req       = '0;
    in_done   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("rst_addr_ok", 32'(rsp.addr_ok), 32'h0);
      chk("rst_data_ok", 32'(rsp.data_ok), 32'h0);
      chk("rst_data",    rsp.data,          32'h0);
      chk("rst_state",   32'(dbg_state),    32'h0);
    end
    resetn = 1'b1;
  endtask

  task automatic idle(input int n);
    req.valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      in_done = 1'b0;
      chk("idle_data_ok", 32'(rsp.data_ok), 32'h0);
      chk("idle_addr_ok", 32'(rsp.addr_ok), 32'h0);
    end
  endtask

  // One complete transaction; expectations come from the word-array model.
  task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input bit drop, input bit b2b, input string tag);
    int n;
    int t_hs;
    int idx;
    logic [31:0] e;
    idx = int'((a >> 2) % MEM_WORDS);
    e   = (s == 4'h0) ? model[idx] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    exp_q.push_back(e);

    req.valid  = 1'b1;
    req.addr   = a;
    req.size   = 3'd2;
    req.strobe = s;
    req.data   = d;
    #1;
    n = 0;
    while (n < HS_MAX) begin
      if (!in_done) begin
        chk({tag, " addr_ok"},      32'(rsp.addr_ok), exp_addr_ok());
        chk({tag, " data_ok_idle"}, 32'(rsp.data_ok), 32'h0);
      end
      if (rsp.addr_ok) break;
      in_done = 1'b0;
      @(negedge clk); #1;
      n++;
    end
    in_done = 1'b0;
    chk({tag, " hs_timeout"}, 32'(n < HS_MAX), 32'h1);
    t_hs = cyc;
`ifndef DBUS_RESP_STALL_EN
    if (b2b) chk({tag, " hs_spacing"}, 32'(t_hs - last_hs), 32'(LAT + 1));
`endif
    last_hs = t_hs;

    @(negedge clk); #1;
    if (drop) begin
      req.valid  = 1'b0;
      req.addr   = $urandom;
      req.data   = $urandom;
      req.strobe = 4'($urandom_range(0, 15));
    end
    n = 0;
    while (!rsp.data_ok && n < LAT + 4) begin
      chk({tag, " busy_addr_ok"}, 32'(rsp.addr_ok), 32'h0);
      @(negedge clk); #1;
      n++;
    end
    chk({tag, " ok_timeout"}, 32'(rsp.data_ok), 32'h1);
    chk({tag, " latency"},    32'(cyc - t_hs), 32'(LAT));
    chk({tag, " data"},       rsp.data,        exp_q.pop_front());
    last_rdata = rsp.data;
    in_done    = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int idx;
    logic [31:0] a;
    logic [3:0]  s;

    // 1. Reset held 3 cycles.
    reset_dut(3);
    idle(2);

    // 2. Full-word write then read.
    access(32'h40, 4'hF, 32'h12345678, 1'b0, 1'b0, "t2_wr");
    access(32'h40, 4'h0, 32'h0,        1'b0, 1'b0, "t2_rd");
    chk("t2_value", last_rdata, 32'h12345678);

    // 3. Single byte lane write.
    access(32'h40, 4'b0010, 32'h0000AB00, 1'b0, 1'b0, "t3_wr");
    idle(1);
    access(32'h40, 4'h0,    32'h0,        1'b0, 1'b0, "t3_rd");
    chk("t3_value", last_rdata, 32'h1234AB78);

    // 4. Address wrap at MEM_WORDS*4.
    access(32'h0,    4'hF, 32'hCAFEF00D, 1'b0, 1'b0, "t4_wr");
    access(32'h1000, 4'h0, 32'h0,        1'b0, 1'b0, "t4_rd");
    chk("t4_value", last_rdata, 32'hCAFEF00D);

    // 5. Back-to-back reads with valid held high.
    access(32'h40,   4'h0, 32'h0, 1'b0, 1'b0, "t5_rd0");
    access(32'h0,    4'h0, 32'h0, 1'b0, 1'b1, "t5_rd1");
    access(32'h1040, 4'h0, 32'h0, 1'b0, 1'b1, "t5_rd2");
    access(32'h3,    4'h0, 32'h0, 1'b0, 1'b1, "t5_rd3");
    idle(1);

    // 6. Reset while a write to 0x80 is waiting.
    access(32'h80, 4'hF, 32'h5A5A5A5A, 1'b0, 1'b0, "t6_pre");
    req.valid  = 1'b1;
    req.addr   = 32'h80;
    req.strobe = 4'hF;
    req.data   = 32'hFFFFFFFF;
    #1;
    n = 0;
    while (!rsp.addr_ok && n < HS_MAX) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_hs_timeout", 32'(n < HS_MAX), 32'h1);
    @(negedge clk); #1;
    chk("t6_wait_data_ok", 32'(rsp.data_ok), 32'h0);
    reset_dut(2);
    in_done = 1'b0;
    idle(LAT + 3);
    access(32'h80, 4'h0, 32'h0, 1'b0, 1'b0, "t6_rd");
    chk("t6_value", last_rdata, 32'h5A5A5A5A);

    // 7. Randomized traffic over 16 preset words with aliased addresses.
    for (int i = 0; i < 16; i++)
      access(32'((256 + i) << 2), 4'hF, $urandom, 1'b0, 1'b0, "t7_init");
    for (int i = 0; i < 80; i++) begin
      idx = 256 + int'($urandom_range(0, 15));
      a   = 32'(idx << 2) | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 7)) << 12);
      s   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(a, s, $urandom, ($urandom_range(0, 3) == 0), 1'b0, "t7_rand");
      if ($urandom_range(0, 9) < 3) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
